alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that lends one shared multi-cycle ALU to two
// requesters, captures results and flags, and aborts with res_err on a wait timeout.
module alu_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_req,
    input  logic [15:0] r0_a,
    input  logic [15:0] r0_b,
    input  logic [7:0]  r0_cins,
    input  logic        r0_cin,
    output logic        r0_ack,

    input  logic        r1_req,
    input  logic [15:0] r1_a,
    input  logic [15:0] r1_b,
    input  logic [7:0]  r1_cins,
    input  logic        r1_cin,
    output logic        r1_ack,

    output logic [15:0] res_out,
    output logic        res_carry,
    output logic        res_over,
    output logic        res_cmp,
    output logic        res_err,
    output logic        busy,

    output logic        alu_start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_cins,
    output logic        alu_carryin,
    output logic        alu_oe,
    input  logic        alu_done,
    input  logic [15:0] alu_out,
    input  logic        alu_carryout,
    input  logic        alu_overout,
    input  logic        alu_cmpo
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [6:0] TIMEOUT_CNT = 7'(TIMEOUT);

    state_t      state;
    state_t      state_next;

    logic        grant;
    logic        grant_next;
    logic        grant_load;
    logic        last_grant;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [7:0]  op_cins;
    logic        op_cin;

    logic [5:0]  wait_cnt;
    logic        wait_clear;
    logic        wait_inc;
    logic        wait_expired;

    logic        cmp_sticky;
    logic        capture;
    logic        abort;

    // The counter is compared one ahead so exactly TIMEOUT cycles are spent waiting.
    assign wait_expired = (({1'b0, wait_cnt} + 7'd1) == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        grant_load = 1'b0;
        wait_clear = 1'b0;
        wait_inc   = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    grant_load = 1'b1;
                    grant_next = (r0_req && r1_req) ? ~last_grant : r1_req;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wait_clear = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                wait_inc = 1'b1;
                if (wait_expired) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end else if (!alu_done) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A completion seen in the same cycle as expiry still counts as success.
                wait_inc = 1'b1;
                if (alu_done) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else if (wait_expired) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_cins    <= '0;
            op_cin     <= 1'b0;
        end else begin
            if (grant_load) begin
                grant   <= grant_next;
                op_a    <= grant_next ? r1_a    : r0_a;
                op_b    <= grant_next ? r1_b    : r0_b;
                op_cins <= grant_next ? r1_cins : r0_cins;
                op_cin  <= grant_next ? r1_cin  : r0_cin;
            end
            if (state == RESP) begin
                last_grant <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            cmp_sticky <= 1'b0;
        end else begin
            if (wait_clear) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 6'd1;
            end
            if (wait_clear) begin
                cmp_sticky <= 1'b0;
            end else if ((state == WAIT_DONE) && alu_cmpo) begin
                cmp_sticky <= 1'b1;
            end
        end
    end

    // Result registers only move on the transition into RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_out   <= '0;
            res_carry <= 1'b0;
            res_over  <= 1'b0;
            res_cmp   <= 1'b0;
            res_err   <= 1'b0;
        end else if (capture) begin
            res_out   <= alu_out;
            res_carry <= alu_carryout;
            res_over  <= alu_overout;
            res_cmp   <= cmp_sticky | alu_cmpo;
            res_err   <= 1'b0;
        end else if (abort) begin
            res_out   <= '0;
            res_carry <= 1'b0;
            res_over  <= 1'b0;
            res_cmp   <= 1'b0;
            res_err   <= 1'b1;
        end
    end

    assign busy        = (state != IDLE);
    assign alu_start   = (state == ISSUE);
    assign alu_oe      = (state == WAIT_DONE) || (state == RESP);
    assign r0_ack      = (state == RESP) && !grant;
    assign r1_ack      = (state == RESP) && grant;

    assign alu_a       = busy ? op_a    : '0;
    assign alu_b       = busy ? op_b    : '0;
    assign alu_cins    = busy ? op_cins : '0;
    assign alu_carryin = busy ? op_cin  : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives two requesters and a behavioural ALU, scoreboarding each
// ack against results computed from the requester's own operands.
module tb_alu_arbiter;

    localparam int TB_TIMEOUT = 20;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_CMP  = 8'h10;
    localparam logic [7:0] OP_HANG = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [15:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [7:0]  r0_cins = '0, r1_cins = '0;
    logic        r0_cin = 1'b0, r1_cin = 1'b0;
    logic        r0_ack, r1_ack;
    logic [15:0] res_out;
    logic        res_carry, res_over, res_cmp, res_err, busy;
    logic        alu_start, alu_carryin, alu_oe;
    logic [15:0] alu_a, alu_b;
    logic [7:0]  alu_cins;
    logic        alu_done = 1'b1;
    logic [15:0] alu_out = '0;
    logic        alu_carryout = 1'b0, alu_overout = 1'b0, alu_cmpo = 1'b0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  cins;
        logic        cin;
        logic [19:0] res;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   ord_q[$];

    int compared = 0;
    int failed = 0;
    int cycle = 0;

    int          start_cnt = 0;
    int          start_cycle = 0;
    bit          op_changed = 0;
    logic [40:0] lat_ops = '0;
    int          phase = 0;
    int          pre_left = 0;
    int          lo_left = 0;
    bit          cmp_hit = 0;
    logic [19:0] alu_res = '0;

    logic [19:0] prev_res = '0;
    bit          prev_valid = 0;
    logic [19:0] res_vec;
    exp_t        mon_e;
    int          mon_who;

    alu_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_cins(r0_cins), .r0_cin(r0_cin), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_cins(r1_cins), .r1_cin(r1_cin), .r1_ack(r1_ack),
        .res_out(res_out), .res_carry(res_carry), .res_over(res_over), .res_cmp(res_cmp),
        .res_err(res_err), .busy(busy),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_cins(alu_cins),
        .alu_carryin(alu_carryin), .alu_oe(alu_oe), .alu_done(alu_done), .alu_out(alu_out),
        .alu_carryout(alu_carryout), .alu_overout(alu_overout), .alu_cmpo(alu_cmpo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference ALU semantics: {out, carry, over, cmp, err}; unknown opcodes never finish.
    function automatic logic [19:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] cins, input logic cin);
        logic [16:0] wide;
        logic [15:0] o;
        logic        c, v, m, e;
        o = '0; c = 1'b0; v = 1'b0; m = 1'b0; e = 1'b0;
        case (cins)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b} + 17'(cin);
                o = wide[15:0]; c = wide[16];
                v = (a[15] == b[15]) && (o[15] != a[15]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                o = wide[15:0]; c = wide[16];
                v = (a[15] != b[15]) && (o[15] != a[15]);
            end
            OP_AND: o = a & b;
            OP_XOR: o = a ^ b;
            OP_CMP: m = (a < b);
            default: e = 1'b1;
        endcase
        return {o, c, v, m, e};
    endfunction

    function automatic logic [7:0] pick_cins();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return OP_ADD;
            2, 3:    return OP_SUB;
            4:       return OP_AND;
            5:       return OP_XOR;
            6, 7, 8: return OP_CMP;
            default: return OP_HANG;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] cins, input logic cin,
                                 input bit scramble, input bit drop_early);
        exp_t e;
        bit   got;
        int   waited;
        e.a = a; e.b = b; e.cins = cins; e.cin = cin;
        e.res = alu_ref(a, b, cins, cin);
        if (who == 0) begin
            exp_q0.push_back(e);
            r0_a = a; r0_b = b; r0_cins = cins; r0_cin = cin; r0_req = 1'b1;
        end else begin
            exp_q1.push_back(e);
            r1_a = a; r1_b = b; r1_cins = cins; r1_cin = cin; r1_req = 1'b1;
        end
        got = 0;
        waited = 0;
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            if ((who == 0) ? r0_ack : r1_ack) begin
                got = 1;
            end else if (busy) begin
                if (scramble) begin
                    if (who == 0) r0_a = 16'($urandom); else r1_a = 16'($urandom);
                end
                if (drop_early) begin
                    if (who == 0) r0_req = 1'b0; else r1_req = 1'b0;
                end
            end
        end
        if (who == 0) r0_req = 1'b0; else r1_req = 1'b0;
        if (!got) begin
            compared++;
            failed++;
            $display("[TB] FAIL ack_timeout r%0d: no ack after %0d cycles, required one ack", who, waited);
        end
    endtask

    // Behavioural ALU: done drops a few cycles after start, optional compare pulse
    // in the last busy cycle, results presented as done rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            alu_done = 1'b1; alu_cmpo = 1'b0;
            alu_out = '0; alu_carryout = 1'b0; alu_overout = 1'b0;
            phase = 0; start_cnt = 0; op_changed = 0;
        end else if (alu_start) begin
            start_cnt++;
            start_cycle = cycle;
            op_changed = 0;
            lat_ops = {alu_a, alu_b, alu_cins, alu_carryin};
            alu_res = alu_ref(alu_a, alu_b, alu_cins, alu_carryin);
            cmp_hit = (alu_cins == OP_CMP) && alu_res[1];
            pre_left = $urandom_range(0, 2);
            lo_left = $urandom_range(2, 5);
            phase = alu_res[0] ? 3 : 1;
        end else begin
            if (busy && ({alu_a, alu_b, alu_cins, alu_carryin} != lat_ops)) op_changed = 1;
            case (phase)
                1: begin
                    if (pre_left == 0) begin
                        phase = 2;
                        alu_done = 1'b0;
                        alu_cmpo = (lo_left == 1) && cmp_hit;
                    end else begin
                        pre_left--;
                    end
                end
                2: begin
                    lo_left--;
                    if (lo_left == 0) begin
                        alu_done = 1'b1;
                        alu_cmpo = 1'b0;
                        alu_out = alu_res[19:4];
                        alu_carryout = alu_res[3];
                        alu_overout = alu_res[2];
                        phase = 0;
                    end else begin
                        alu_cmpo = (lo_left == 1) && cmp_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        res_vec = {res_out, res_carry, res_over, res_cmp, res_err};
        if (!rst_n) begin
            prev_valid = 0;
        end else begin
            if (!busy)
                checkOutput("idle_outputs",
                            64'({alu_start, alu_oe, r0_ack, r1_ack, alu_a, alu_b, alu_cins, alu_carryin}), 64'(0));
            if (r0_ack || r1_ack) begin
                checkOutput("ack_onehot", 64'(r0_ack & r1_ack), 64'(0));
                mon_who = r1_ack ? 1 : 0;
                if ((mon_who == 0 && exp_q0.size() == 0) || (mon_who == 1 && exp_q1.size() == 0)) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL unexpected_ack r%0d: got ack, required none", mon_who);
                end else begin
                    if (mon_who == 0) mon_e = exp_q0.pop_front(); else mon_e = exp_q1.pop_front();
                    checkOutput($sformatf("result_r%0d", mon_who), 64'(res_vec), 64'(mon_e.res));
                    checkOutput("alu_operands_stable",
                                64'({op_changed, alu_a, alu_b, alu_cins, alu_carryin, alu_oe}),
                                64'({1'b0, mon_e.a, mon_e.b, mon_e.cins, mon_e.cin, 1'b1}));
                    checkOutput("start_pulses", 64'(start_cnt), 64'(1));
                    if (mon_e.res[0])
                        checkOutput("timeout_latency", 64'(cycle - start_cycle), 64'(TB_TIMEOUT + 1));
                    if (ord_q.size() > 0)
                        checkOutput("grant_order", 64'(mon_who), 64'(ord_q.pop_front()));
                end
                start_cnt = 0;
            end else if (prev_valid) begin
                checkOutput("res_hold", 64'(res_vec), 64'(prev_res));
            end
            prev_res = res_vec;
            prev_valid = 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", 64'({busy, alu_start, alu_oe, r0_ack, r1_ack, alu_a, alu_b}), 64'(0));
        checkOutput("reset_res", 64'({res_out, res_carry, res_over, res_cmp, res_err}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] tie from reset, alternating grants");
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
        fork
            begin
                applyStimulus(0, 16'h1111, 16'h2222, OP_ADD, 1'b0, 0, 0);
                applyStimulus(0, 16'h8000, 16'h8001, OP_ADD, 1'b1, 0, 0);
            end
            begin
                applyStimulus(1, 16'h00F0, 16'h0FF0, OP_XOR, 1'b0, 0, 0);
                applyStimulus(1, 16'h0005, 16'h0009, OP_SUB, 1'b0, 0, 0);
            end
        join
        @(negedge clk);

        $display("[TB] single add, compare sticky, timeout");
        applyStimulus(0, 16'h0003, 16'h0004, OP_ADD, 1'b0, 0, 0);
        applyStimulus(0, 16'h0010, 16'h0020, OP_CMP, 1'b0, 0, 0);
        applyStimulus(1, 16'h0030, 16'h0020, OP_CMP, 1'b0, 0, 0);
        applyStimulus(0, 16'hABCD, 16'h1234, OP_HANG, 1'b0, 0, 0);

        $display("[TB] operand changes and early request drop");
        applyStimulus(0, 16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1, 0);
        applyStimulus(1, 16'h1234, 16'h0F0F, OP_AND, 1'b1, 1, 1);
        applyStimulus(0, 16'h4000, 16'h0001, OP_SUB, 1'b0, 0, 1);

        $display("[TB] reset during WAIT_DONE");
        r0_a = 16'h5555; r0_b = 16'h1111; r0_cins = OP_ADD; r0_cin = 1'b0; r0_req = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (alu_oe && !r0_ack) got = 1;
        end
        checkOutput("reach_wait_done", 64'(got), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_async_ctrl",
                    64'({busy, alu_oe, alu_start, r0_ack, r1_ack, alu_a, alu_b, alu_cins, alu_carryin}), 64'(0));
        checkOutput("reset_async_res", 64'({res_out, res_carry, res_over, res_cmp, res_err}), 64'(0));
        r0_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 16'h0100, 16'h0023, OP_SUB, 1'b0, 0, 0);

        $display("[TB] randomized contention");
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    applyStimulus(0, 16'($urandom), 16'($urandom), pick_cins(), 1'($urandom_range(0, 1)), 0, 0);
                end
            end
            begin
                for (int j = 0; j < 15; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    applyStimulus(1, 16'($urandom), 16'($urandom), pick_cins(), 1'($urandom_range(0, 1)), 0, 0);
                end
            end
        join

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size() + ord_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
